// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: instruction-memory request/response, decoder hand-off and redirect.
// The fetch unit uses the master modport; memory, decoder and branch logic see the slave side.
interface inst_fetch_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output req_valid, req_addr, inst_valid, inst, inst_pc,
    input  req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_addr, inst_valid, inst, inst_pc,
    output req_ready, resp_valid, resp_data, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: request, wait for the word, hand it to the decoder.
// Redirects squash the in-flight response through the drop flag.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic        drop_q, drop_d;
  logic [31:0] redirect_tgt;

  // Low two bits of every address written into pc are forced to zero, so pc stays word-aligned.
  assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC & 32'hFFFF_FFFC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
      drop_q       <= drop_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first, so no path infers a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;
    drop_d       = drop_q;

    case (state_q)
      S_REQ: begin
        if (bus.req_ready) state_d = S_WAIT;
        if (bus.redirect_valid) begin
          pc_d   = redirect_tgt;
          // An accepted request that already carries the old pc must have its answer discarded.
          drop_d = bus.req_ready;
        end
      end

      S_WAIT: begin
        if (bus.resp_valid) begin
          if (drop_q || bus.redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d       = bus.resp_data;
            inst_pc_d    = pc_q;
            pc_d         = pc_q + 32'd4;
            inst_valid_d = 1'b1;
            state_d      = S_OUT;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
        if (bus.redirect_valid) pc_d = redirect_tgt;
      end

      S_OUT: begin
        // Redirect wins over inst_ready; either way the held instruction is released.
        if (bus.redirect_valid || bus.inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
        if (bus.redirect_valid) pc_d = redirect_tgt;
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  assign bus.req_valid  = (state_q == S_REQ);
  assign bus.req_addr   = pc_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle-accurate vector table for the directed corner cases,
// then a randomized stream against a memory model with an expected-instruction queue.
module tb_inst_fetch;

  localparam logic [31:0] P = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(.RESET_PC(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        inst_ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        chk;
    logic        e_req_valid;
    logic [31:0] e_req_addr;
    logic        e_inst_valid;
    logic [31:0] e_inst;
    logic [31:0] e_inst_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rr, input logic rv, input logic [31:0] rd,
                              input logic ir, input logic rdv, input logic [31:0] rpc, input logic c,
                              input logic erv, input logic [31:0] ea, input logic eiv,
                              input logic [31:0] ei, input logic [31:0] eipc);
    vec_t v;
    v.rst = r; v.req_ready = rr; v.resp_valid = rv; v.resp_data = rd; v.inst_ready = ir;
    v.redir = rdv; v.redir_pc = rpc; v.chk = c; v.e_req_valid = erv; v.e_req_addr = ea;
    v.e_inst_valid = eiv; v.e_inst = ei; v.e_inst_pc = eipc;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_9BDF;
  endfunction

  task automatic drive_idle();
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = '0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
  endtask

  initial begin
    logic        pend;
    logic [31:0] pend_addr;
    int          lat;
    logic [31:0] exp_pc;
    int          got;
    int          cyc;

    drive_idle();

    // Reset, first fetch, decoder stall, request stall.
    vecs.push_back(mk(1,0,0,0,0,0,0, 0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1, 1,P,0,0,0));
    vecs.push_back(mk(0,0,1,32'h0000_0093,0,0,0, 1, 0,0,0,0,0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0,0,0,0,0,0,0, 1, 0,0,1,32'h0000_0093,P));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1, 0,0,1,32'h0000_0093,P));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,0,0,0,0, 1, 1,P+4,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1, 1,P+4,0,0,0));
    // Redirect while waiting; the following response is dropped.
    vecs.push_back(mk(0,0,0,0,0,1,32'h8000_0103, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,32'hDEAD_BEEF,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1, 1,32'h8000_0100,0,0,0));
    // Redirect coincident with handshake, then redirect coincident with inst_ready.
    vecs.push_back(mk(0,1,0,0,0,1,32'h8000_0200, 1, 1,32'h8000_0100,0,0,0));
    vecs.push_back(mk(0,0,1,32'h1111_1111,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'h8000_0200,0,0,0));
    vecs.push_back(mk(0,0,1,32'h2222_2222,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,1,32'h8000_0300, 1, 0,0,1,32'h2222_2222,32'h8000_0200));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'h8000_0300,0,0,0));
    vecs.push_back(mk(0,0,1,32'h3333_3333,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1, 0,0,1,32'h3333_3333,32'h8000_0300));
    // Redirect in S_REQ without handshake to a misaligned top address, then wrap.
    vecs.push_back(mk(0,0,0,0,0,1,32'hFFFF_FFFE, 1, 1,32'h8000_0304,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'hFFFF_FFFC,0,0,0));
    vecs.push_back(mk(0,0,1,32'h4444_4444,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1, 0,0,1,32'h4444_4444,32'hFFFF_FFFC));
    // Stray responses in S_REQ and S_OUT are ignored.
    vecs.push_back(mk(0,1,1,32'h5555_5555,0,0,0, 1, 1,32'h0000_0000,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,32'h6666_6666,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,32'h7777_7777,0,0,0, 1, 0,0,1,32'h6666_6666,0));
    vecs.push_back(mk(0,0,0,0,1,0,0, 1, 0,0,1,32'h6666_6666,0));
    vecs.push_back(mk(0,1,0,0,0,0,0, 1, 1,32'h0000_0004,0,0,0));
    // Reset in S_WAIT with a late response, then reset overriding redirect.
    vecs.push_back(mk(1,0,0,0,0,0,0, 1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,1,32'h8888_8888,0,0,0, 1, 1,P,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1, 1,P,0,0,0));
    vecs.push_back(mk(1,1,0,0,1,1,32'h1234_5678, 1, 1,P,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0, 1, 1,P,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("v%0d req_valid", i), {31'b0, bus.req_valid}, {31'b0, vecs[i].e_req_valid});
        if (vecs[i].e_req_valid)
          check($sformatf("v%0d req_addr", i), bus.req_addr, vecs[i].e_req_addr);
        check($sformatf("v%0d inst_valid", i), {31'b0, bus.inst_valid}, {31'b0, vecs[i].e_inst_valid});
        if (vecs[i].e_inst_valid) begin
          check($sformatf("v%0d inst", i), bus.inst, vecs[i].e_inst);
          check($sformatf("v%0d inst_pc", i), bus.inst_pc, vecs[i].e_inst_pc);
        end
      end
      rst                = vecs[i].rst;
      bus.req_ready      = vecs[i].req_ready;
      bus.resp_valid     = vecs[i].resp_valid;
      bus.resp_data      = vecs[i].resp_data;
      bus.inst_ready     = vecs[i].inst_ready;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].redir_pc;
    end

    // Randomized stream: memory with 1..3 cycle latency, random stalls on both sides.
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    pend      = 1'b0;
    pend_addr = '0;
    lat       = 0;
    exp_pc    = P;
    got       = 0;
    cyc       = 0;
    while (got < 40 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      bus.resp_valid = 1'b0;
      bus.resp_data  = '0;
      if (pend) begin
        if (lat == 0) begin
          bus.resp_valid = 1'b1;
          bus.resp_data  = mem_word(pend_addr);
          pend           = 1'b0;
        end else begin
          lat--;
        end
      end
      bus.req_ready  = ($urandom_range(0, 3) != 0);
      bus.inst_ready = ($urandom_range(0, 2) != 0);
      if (bus.req_valid && bus.req_ready) begin
        check("stream req_addr", bus.req_addr, exp_pc);
        sb_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
        pend      = 1'b1;
        pend_addr = bus.req_addr;
        lat       = $urandom_range(0, 2);
        exp_pc    = exp_pc + 32'd4;
      end
      if (bus.inst_valid && bus.inst_ready) begin
        if (sb_q.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL stream unexpected inst: got pc %h with empty queue", bus.inst_pc);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("stream inst", bus.inst, e.word);
          check("stream inst_pc", bus.inst_pc, e.pc);
          got++;
        end
      end
    end
    check("stream delivered count", got, 40);

    @(negedge clk);
    drive_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
